spi_alu_rx: RTL and testbench
=============================

// Module: spi_alu_rx
// PURPOSE
//   SPI mode-0 slave that receives 12-bit command frames (opcode, operand A, operand B) from the
//   external MCU and presents them, registered, to the ALU whose 4-bit result drives the PWM stage.
//   Returns the current ALU result to the MCU on MISO during each frame.
//   All SPI pins are oversampled in the clk domain; there is no second clock.
// PARAMETERS
//   FRAME_W      12  bits per frame; field layout below is fixed for 12
//   SYNC_STAGES  2   flip-flop stages on sclk, cs_n and mosi (>=2)
// PORTS
//   clk          in   1  system clock
//   rst          in   1  synchronous, active-low reset (0 = reset)
//   sclk         in   1  SPI clock from master, async to clk, idle low
//   cs_n         in   1  SPI chip select, active low, async
//   mosi         in   1  SPI data master->slave, async
//   miso         out  1  SPI data slave->master
//   result_in    in   4  current ALU result, returned on MISO
//   op           out  4  opcode of last complete frame
//   a            out  4  operand A of last complete frame
//   b            out  4  operand B of last complete frame
//   frame_valid  out  1  one-clk pulse: op/a/b just updated
//   frame_err    out  1  one-clk pulse: frame ended before FRAME_W bits
// BEHAVIOUR
// - One clock, clk; rst is synchronous and active-low. Timing constraint: f_sclk <= f_clk/8.
// - Sync: sclk/cs_n/mosi pass SYNC_STAGES flops; reset values sclk=0, cs_n=1, mosi=0.
//   sclk_rise/sclk_fall/cs_fall/cs_rise are 1-clk pulses from synchronized last two samples.
// - Reset outputs: op=a=b=0, frame_valid=0, frame_err=0, miso=0; bit_cnt=0; state=WAIT_HI.
// - Frame: MSB first; bits[11:8]=op, [7:4]=a, [3:0]=b.
// - FSM:
//   WAIT_HI: ignore everything; -> IDLE when synchronized cs_n==1 (no mid-frame start after reset).
//   IDLE:    cs_fall -> SHIFT; bit_cnt=0; tx_sr={result_in,8'h00} (result_in sampled this clk).
//   SHIFT:   sclk_rise: rx_sr={rx_sr[10:0],mosi}, bit_cnt+1. sclk_fall: tx_sr<<=1, LSB fill 0.
//            bit_cnt reaching FRAME_W (after 12th rise) -> DONE.
//            cs_rise with bit_cnt<FRAME_W -> frame_err=1 next clk, op/a/b unchanged, -> IDLE.
//   DONE:    one clk: op/a/b <= rx_sr fields, frame_valid=1 on same edge; -> TAIL.
//   TAIL:    extra sclk edges ignored, no second frame_valid/err; cs_rise -> IDLE.
// - Latency: frame_valid/op/a/b update 2 clk after the clk in which 12th sclk_rise is detected.
// - cs_rise and 12th sclk_rise in same clk: frame counts as complete (no frame_err), then IDLE.
// - miso = tx_sr[11] while synchronized cs_n==0 and state in {SHIFT,TAIL}; else 0.
//   First bit valid before first sclk rise; result bits 11..8 = result_in[3:0], rest 0.
// - bit_cnt is 4 bits, saturates at FRAME_W (no wrap on long frames).
// - rst low at any time: discard partial frame, outputs to reset values, state=WAIT_HI.
// - Back-to-back frames: cs_n high >= 4 clk between frames is sufficient; each frame -> 1 pulse.
// TESTING
// 1. rst low 2 clk, release; cs_n=1: op=a=b=0, miso=0, no pulses; FSM reaches IDLE.
// 2. Frame 12'h3A5 -> op=4'h3, a=4'hA, b=4'h5, frame_valid high exactly 1 clk, frame_err=0.
// 3. result_in=4'hC at cs_n fall -> MISO bits read by master = 1100_0000_0000.
// 4. After test 2, 7 bits then cs_n high -> frame_err 1 clk, op/a/b stay 3/A/5, no frame_valid.
// 5. 16-bit frame 16'h7E1F -> op=7, a=E, b=1 (first 12 bits); single frame_valid, no frame_err.
// 6. rst low after 6 bits, released with cs_n still low, 6 more sclk -> no pulses; then cs_n high
//    and full frame 12'h0F0 -> op=0, a=F, b=0, one frame_valid.

Source files
------------

// File: rtl/spi_alu_rx.sv
// SPI mode-0 slave that captures 12-bit {op, a, b} command frames for the ALU and
// shifts the current ALU result back out on MISO. All SPI pins are oversampled on clk.
`timescale 1ns/1ps

module spi_alu_rx #(
  parameter int unsigned FRAME_W     = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic [3:0] result_in,
  output logic [3:0] op,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] FrameCnt = CntW'(FRAME_W);
  localparam logic [CntW-1:0] LastCnt  = CntW'(FRAME_W - 1);
  localparam logic [7:0]      WarmCnt  = 8'(SYNC_STAGES);

  typedef enum logic [2:0] {
    StWaitHi,
    StIdle,
    StShift,
    StDone,
    StTail
  } state_e;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic [7:0]             warm_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic warm_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      warm_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      if (!warm_done) begin
        warm_q <= warm_q + 8'd1;
      end
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  // The chain holds reset values until real pin samples reach its end; trust cs_s only after.
  assign warm_done = (warm_q >= WarmCnt);

  // Frame FSM
  state_e               state_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic [FRAME_W-1:0]   rx_sr_q;
  logic [FRAME_W-1:0]   tx_sr_q;
  logic [3:0]           op_q, a_q, b_q;
  logic                 frame_valid_q, frame_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StWaitHi;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      unique case (state_q)
        StWaitHi: begin
          if (warm_done && cs_s) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (cs_fall) begin
            state_q   <= StShift;
            bit_cnt_q <= '0;
            tx_sr_q   <= {result_in, {(FRAME_W-4){1'b0}}};
          end
        end
        StShift: begin
          if (sclk_rise) begin
            rx_sr_q <= {rx_sr_q[FRAME_W-2:0], mosi_s};
            if (bit_cnt_q != FrameCnt) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sclk_fall) begin
            tx_sr_q <= {tx_sr_q[FRAME_W-2:0], 1'b0};
          end
          // A final bit arriving together with cs_rise still completes the frame.
          if (sclk_rise && (bit_cnt_q == LastCnt)) begin
            state_q <= StDone;
          end else if (cs_rise) begin
            frame_err_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        StDone: begin
          op_q          <= rx_sr_q[FRAME_W-1 -: 4];
          a_q           <= rx_sr_q[FRAME_W-5 -: 4];
          b_q           <= rx_sr_q[FRAME_W-9 -: 4];
          frame_valid_q <= 1'b1;
          state_q       <= cs_s ? StIdle : StTail;
        end
        StTail: begin
          if (cs_rise) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StWaitHi;
      endcase
    end
  end

  assign op          = op_q;
  assign a           = a_q;
  assign b           = b_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign miso        = ~cs_s & ((state_q == StShift) || (state_q == StTail)) &
                       tx_sr_q[FRAME_W-1];

endmodule

// File: tb/tb_spi_alu_rx.sv
// Bench for spi_alu_rx: SPI master model, frame table, random frames against a reference model,
// and hand sequences for latency, cs/sclk coincidence and mid-frame reset.
`timescale 1ns/1ps

module tb_spi_alu_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [3:0] result_in = 4'h0;
  logic [3:0] op, a, b;
  logic       frame_valid, frame_err;

  spi_alu_rx dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .result_in   (result_in),
    .op          (op),
    .a           (a),
    .b           (b),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  int ecnt = 0;

  // Count every clk cycle in which a pulse is high; a frame must contribute exactly one.
  always @(negedge clk) begin
    if (frame_valid) vcnt++;
    if (frame_err) ecnt++;
  end

  // Reference model state: fields of the last complete frame
  logic [3:0] m_op = 4'h0, m_a = 4'h0, m_b = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Result nibble MSB first, then zeros, for as many bits as the master clocks.
  function automatic logic [15:0] exp_miso(input logic [3:0] res, input int n);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[14:0], (i < 4) ? res[3-i] : 1'b0};
    return v;
  endfunction

  // A frame of n>=12 bits carries {op,a,b} in its first 12 bits; shorter frames change nothing.
  task automatic model_update(input logic [15:0] data, input int n);
    logic [11:0] f;
    if (n >= 12) begin
      f = 12'(data >> (n - 12));
      m_op = f[11:8];
      m_a  = f[7:4];
      m_b  = f[3:0];
    end
  endtask

  // Mode-0 master: sclk half-period of 4 clk, MISO sampled just before each rising edge.
  task automatic spi_frame(input logic [15:0] data, input int n, input logic [3:0] res,
                           output logic [15:0] mbits);
    mbits = '0;
    result_in = res;
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < n; i++) begin
      mosi = data[n-1-i];
      wait_clk(4);
      mbits = {mbits[14:0], miso};
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic run_check(input string tag, input logic [15:0] data, input int n,
                           input logic [3:0] res, input logic [3:0] eop, input logic [3:0] ea,
                           input logic [3:0] eb, input int ev, input int ee,
                           input logic [15:0] em);
    int v0, e0;
    logic [15:0] mb;
    v0 = vcnt;
    e0 = ecnt;
    spi_frame(data, n, res, mb);
    check({tag, ".op"}, op, eop);
    check({tag, ".a"}, a, ea);
    check({tag, ".b"}, b, eb);
    check({tag, ".valid_cnt"}, vcnt - v0, ev);
    check({tag, ".err_cnt"}, ecnt - e0, ee);
    check({tag, ".miso_bits"}, mb, em);
    check({tag, ".miso_idle"}, miso, 1'b0);
  endtask

  typedef struct {
    logic [15:0] data;
    int          nbits;
    logic [3:0]  res;
    logic [3:0]  eop, ea, eb;
    int          ev, ee;
    logic [15:0] emiso;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] d, em, mb;
    logic [3:0]  r;
    int          n, v0, e0, lat;
    logic [11:0] f;

    vecs[0] = '{16'h03A5, 12, 4'hC, 4'h3, 4'hA, 4'h5, 1, 0, 16'h0C00};
    vecs[1] = '{16'h0055,  7, 4'h3, 4'h3, 4'hA, 4'h5, 0, 1, 16'h0018};
    vecs[2] = '{16'h7E1F, 16, 4'h9, 4'h7, 4'hE, 4'h1, 1, 0, 16'h9000};
    vecs[3] = '{16'h05C3, 12, 4'h6, 4'h5, 4'hC, 4'h3, 1, 0, 16'h0600};

    // Reset with cs_n idle high
    rst = 1'b0;
    wait_clk(2);
    check("rst.op", op, 4'h0);
    check("rst.miso", miso, 1'b0);
    check("rst.valid", frame_valid, 1'b0);
    rst = 1'b1;
    wait_clk(6);
    check("post_rst.abo", {op, a, b}, 12'h000);
    check("post_rst.pulses", vcnt + ecnt, 0);

    for (int i = 0; i < 4; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].nbits, vecs[i].res, vecs[i].eop,
                vecs[i].ea, vecs[i].eb, vecs[i].ev, vecs[i].ee, vecs[i].emiso);
      model_update(vecs[i].data, vecs[i].nbits);
    end

    // Latency from the 12th sclk rise to frame_valid, and pulse width
    d = 16'h01E7;
    v0 = vcnt;
    cs_n = 1'b0;
    wait_clk(4);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      mosi = d[11-i];
      wait_clk(4);
      sclk = 1'b1;
      if (i == 11) begin
        while (!frame_valid && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        check("lat.cycles", lat, 4);
        check("lat.op_a_b", {op, a, b}, 12'h1E7);
        @(negedge clk);
        check("lat.width", frame_valid, 1'b0);
        wait_clk(2);
      end else begin
        wait_clk(4);
      end
      sclk = 1'b0;
    end
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    check("lat.valid_cnt", vcnt - v0, 1);
    model_update(d, 12);

    // cs_n rises together with the 12th sclk rise: still a complete frame
    d = 16'h02B4;
    v0 = vcnt;
    e0 = ecnt;
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 12; i++) begin
      mosi = d[11-i];
      wait_clk(4);
      sclk = 1'b1;
      if (i == 11) cs_n = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(8);
    check("coinc.op_a_b", {op, a, b}, 12'h2B4);
    check("coinc.valid_cnt", vcnt - v0, 1);
    check("coinc.err_cnt", ecnt - e0, 0);
    model_update(d, 12);
    run_check("coinc_next", 16'h0C3E, 12, 4'hA, 4'hC, 4'h3, 4'hE, 1, 0, 16'h0A00);
    model_update(16'h0C3E, 12);

    // Random frames against the model
    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(1, 16);
      d = 16'($urandom);
      r = 4'($urandom);
      model_update(d, n);
      em = exp_miso(r, n);
      run_check($sformatf("rnd%0d", i), d, n, r, m_op, m_a, m_b, (n >= 12) ? 1 : 0,
                (n < 12) ? 1 : 0, em);
    end

    // Reset in the middle of a frame, released while cs_n is still low
    v0 = vcnt;
    e0 = ecnt;
    d = 16'h0ABC;
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        rst = 1'b0;
        wait_clk(2);
        rst = 1'b1;
      end
      mosi = d[11-i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    check("midrst.op_a_b", {op, a, b}, 12'h000);
    check("midrst.valid_cnt", vcnt - v0, 0);
    check("midrst.err_cnt", ecnt - e0, 0);
    m_op = 4'h0;
    m_a  = 4'h0;
    m_b  = 4'h0;
    f = 12'h0F0;
    run_check("after_rst", {4'h0, f}, 12, 4'h5, 4'h0, 4'hF, 4'h0, 1, 0, exp_miso(4'h5, 12));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
